// File: rtl/fifo_drain_pkg.sv
// fifo_drain_pkg: shared FSM encodings and buffer depth for the FIFO read engine
package fifo_drain_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;
  localparam int BUF_DEPTH = 2;
endpackage

// File: rtl/fifo_drain_buf2.sv
// stream_buf2: 2-entry circular valid/ready buffer with push, pop and flush
module stream_buf2
  import fifo_drain_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] head,
  output logic         valid,
  output logic [1:0]   occ
);
  logic [W-1:0] mem_q [BUF_DEPTH];
  logic [W-1:0] mem_d [BUF_DEPTH];
  logic         wr_q, wr_d, rd_q, rd_d, do_push, do_pop;
  logic [1:0]   cnt_q, cnt_d;
  // Next pointers/occupancy; flush wins over any push or pop in the same cycle
  always_comb begin
    do_pop  = pop && (cnt_q != 2'd0);
    do_push = push && ((cnt_q != 2'(BUF_DEPTH)) || do_pop);
    mem_d   = mem_q;
    if (do_push) mem_d[wr_q] = push_data;
    wr_d  = flush ? 1'b0 : wr_q ^ do_push;
    rd_d  = flush ? 1'b0 : rd_q ^ do_pop;
    cnt_d = flush ? 2'd0 : cnt_q + 2'(do_push) - 2'(do_pop);
  end
  // Storage and pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  assign head  = mem_q[rd_q];
  assign valid = cnt_q != 2'd0;
  assign occ   = cnt_q;
endmodule

// File: rtl/fifo_drain.sv
// fifo_drain: read-side engine turning FIFO read/ack handshakes into a packetised stream
module fifo_drain
  import fifo_drain_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int PKT_LEN     = 16,
  parameter int CNT_WIDTH   = 16,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  fifo_fempty,
  output logic                  fifo_rd,
  input  logic [DATA_WIDTH-1:0] fifo_q,
  input  logic                  fifo_rack,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  input  logic                  flush,
  output logic                  busy,
  output logic                  rack_err,
  output logic [CNT_WIDTH-1:0]  word_cnt
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int IW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  state_t               state_q, state_d;
  logic [TW-1:0]        tmr_q, tmr_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d, drop_q, drop_d;
  logic                 outstanding, credit, timeout, keep, is_last;
  logic [1:0]           occ;
  logic [DATA_WIDTH:0]  head;
  assign outstanding = state_q != ST_IDLE;
  assign credit      = (3'(occ) + 3'(outstanding)) < 3'(BUF_DEPTH);
  assign timeout     = (state_q == ST_WAIT) && !fifo_rack && (tmr_q == TW'(ACK_TIMEOUT - 1));
  assign keep        = (state_q == ST_WAIT) && fifo_rack && !drop_q && !flush;
  assign is_last     = idx_q == IW'(PKT_LEN - 1);
  // Read FSM, ack timer, packet position, drop marker for reads straddling a flush
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    drop_d  = drop_q | (flush & outstanding);
    err_d   = err_q | timeout;
    idx_d   = flush ? '0 : keep ? (is_last ? '0 : idx_q + IW'(1)) : idx_q;
    cnt_d   = cnt_q + CNT_WIDTH'(m_valid & m_ready);
    case (state_q)
      ST_IDLE: state_d = (!fifo_fempty && credit && !flush) ? ST_REQ : ST_IDLE;
      ST_REQ: begin
        state_d = ST_WAIT;
        tmr_d   = '0;
      end
      ST_WAIT: begin
        state_d = (fifo_rack || timeout) ? ST_IDLE : ST_WAIT;
        tmr_d   = tmr_q + TW'(1);
        drop_d  = (fifo_rack || timeout) ? 1'b0 : drop_d;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  // Control registers
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end
  stream_buf2 #(.W(DATA_WIDTH + 1)) u_buf (
    .clk       (rclk),
    .rst       (rrst),
    .push      (keep),
    .push_data ({is_last, fifo_q}),
    .pop       (m_ready),
    .flush     (flush),
    .head      (head),
    .valid     (m_valid),
    .occ       (occ)
  );
  assign fifo_rd  = state_q == ST_REQ;
  assign m_data   = head[DATA_WIDTH-1:0];
  assign m_last   = head[DATA_WIDTH];
  assign busy     = outstanding | m_valid;
  assign rack_err = err_q;
  assign word_cnt = cnt_q;
endmodule

// File: tb/tb_fifo_drain.sv
// tb_fifo_drain: directed checks of fifo_drain with PKT_LEN=16 (dut_a) and PKT_LEN=4 (dut_b) in lockstep
module tb_fifo_drain;
  logic       rclk = 0, rrst = 1, flush = 0, m_ready = 0;
  logic       t_fempty = 1, t_rack = 0, md_fempty = 1, md_rack = 0;
  logic [7:0] t_q = 0, md_q = 0;
  logic       model_on = 0, mon_on = 0;
  logic       fifo_fempty, fifo_rack;
  logic [7:0] fifo_q;
  logic       rd_a, valid_a, last_a, busy_a, err_a;
  logic       rd_b, valid_b, last_b, busy_b, err_b;
  logic [7:0] data_a, data_b;
  logic [15:0] wc_a, wc_b;
  logic [7:0] fmem [16];
  int         flen = 0, fidx = 0;
  logic       pend = 0;
  logic [7:0] pend_d = 0;
  logic [7:0] got_d [32];
  logic       got_la [32], got_lb [32];
  int         got_n = 0, rd_cnt = 0;
  int         checks = 0, failures = 0;

  assign fifo_fempty = model_on ? md_fempty : t_fempty;
  assign fifo_rack   = model_on ? md_rack : t_rack;
  assign fifo_q      = model_on ? md_q : t_q;

  always #5 rclk = ~rclk;

  fifo_drain #(.DATA_WIDTH(8), .PKT_LEN(16), .CNT_WIDTH(16), .ACK_TIMEOUT(4)) dut_a (
    .rclk(rclk), .rrst(rrst), .fifo_fempty(fifo_fempty), .fifo_rd(rd_a), .fifo_q(fifo_q),
    .fifo_rack(fifo_rack), .m_data(data_a), .m_valid(valid_a), .m_last(last_a), .m_ready(m_ready),
    .flush(flush), .busy(busy_a), .rack_err(err_a), .word_cnt(wc_a));

  fifo_drain #(.DATA_WIDTH(8), .PKT_LEN(4), .CNT_WIDTH(16), .ACK_TIMEOUT(4)) dut_b (
    .rclk(rclk), .rrst(rrst), .fifo_fempty(fifo_fempty), .fifo_rd(rd_b), .fifo_q(fifo_q),
    .fifo_rack(fifo_rack), .m_data(data_b), .m_valid(valid_b), .m_last(last_b), .m_ready(m_ready),
    .flush(flush), .busy(busy_b), .rack_err(err_b), .word_cnt(wc_b));

  // FIFO model: a read strobe seen in one cycle is acknowledged with data in the next
  always @(negedge rclk) begin
    if (!model_on) begin
      fidx = 0; pend = 0; md_rack = 0; md_fempty = 1;
    end else begin
      md_rack = pend;
      if (pend) md_q = pend_d;
      pend = 0;
      if (rd_a && fidx < flen) begin pend = 1; pend_d = fmem[fidx]; fidx++; end
      md_fempty = fidx >= flen;
    end
  end

  // Stream monitor: records accepted words and counts read strobes
  always @(negedge rclk) begin
    #1;
    if (!mon_on) begin
      got_n = 0; rd_cnt = 0;
    end else begin
      if (rd_a) rd_cnt++;
      if (valid_a && m_ready && got_n < 32) begin
        got_d[got_n] = data_a; got_la[got_n] = last_a; got_lb[got_n] = last_b; got_n++;
      end
    end
  end

  task automatic do_reset();
    model_on = 0; mon_on = 0; flush = 0; m_ready = 0;
    t_fempty = 1; t_rack = 0; t_q = 0; flen = 0;
    rrst = 1;
    repeat (2) @(negedge rclk);
    rrst = 0;
    @(negedge rclk);
  endtask

  task automatic load(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) fmem[i] = 8'(base + 8'(i));
    flen = n;
  endtask

  task automatic wait_words(input int n);
    for (int i = 0; i < 300 && got_n < n; i++) @(negedge rclk);
    #2;
  endtask

  task automatic test_reset();
    rrst = 1;
    @(negedge rclk); #2;
    checks++; if ({rd_a, valid_a, last_a, busy_a, err_a} !== 5'b0) begin failures++; $display("FAIL reset_flags: got %b want 00000", {rd_a, valid_a, last_a, busy_a, err_a}); end
    checks++; if (data_a !== 8'h00) begin failures++; $display("FAIL reset_data: got %h want 00", data_a); end
    checks++; if (wc_a !== 16'd0) begin failures++; $display("FAIL reset_wc: got %0d want 0", wc_a); end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    load(8'h11, 4); m_ready = 1; mon_on = 1; model_on = 1;
    wait_words(4);
    repeat (10) @(negedge rclk); #2;
    checks++; if (got_n !== 4) begin failures++; $display("FAIL basic_count: got %0d want 4", got_n); end
    checks++; if (rd_cnt !== 4) begin failures++; $display("FAIL basic_rd: got %0d want 4", rd_cnt); end
    checks++; if (wc_a !== 16'd4) begin failures++; $display("FAIL basic_wc: got %0d want 4", wc_a); end
    for (int i = 0; i < 4 && i < got_n; i++) begin
      checks++; if (got_d[i] !== 8'(8'h11 + 8'(i))) begin failures++; $display("FAIL basic_data[%0d]: got %h want %h", i, got_d[i], 8'(8'h11 + 8'(i))); end
      checks++; if (got_la[i] !== 1'b0) begin failures++; $display("FAIL basic_last[%0d]: got %b want 0", i, got_la[i]); end
    end
  endtask

  task automatic test_pkt();
    do_reset();
    load(8'h00, 9); m_ready = 1; mon_on = 1; model_on = 1;
    wait_words(9);
    repeat (5) @(negedge rclk); #2;
    checks++; if (got_n !== 9) begin failures++; $display("FAIL pkt_count: got %0d want 9", got_n); end
    for (int i = 0; i < 9 && i < got_n; i++) begin
      checks++; if (got_d[i] !== 8'(i)) begin failures++; $display("FAIL pkt_data[%0d]: got %h want %h", i, got_d[i], 8'(i)); end
      checks++; if (got_lb[i] !== (i % 4 == 3)) begin failures++; $display("FAIL pkt_last[%0d]: got %b want %b", i, got_lb[i], (i % 4 == 3)); end
    end
    checks++; if (dut_b.idx_q !== 2'd1) begin failures++; $display("FAIL pkt_index: got %0d want 1", dut_b.idx_q); end
    checks++; if (wc_b !== 16'd9) begin failures++; $display("FAIL pkt_wc: got %0d want 9", wc_b); end
  endtask

  task automatic test_backpressure();
    do_reset();
    load(8'hA0, 5); mon_on = 1; model_on = 1;
    repeat (30) @(negedge rclk); #2;
    checks++; if (rd_cnt !== 2) begin failures++; $display("FAIL bp_reads: got %0d want 2", rd_cnt); end
    checks++; if ({valid_a, rd_a, busy_a} !== 3'b101) begin failures++; $display("FAIL bp_state: got %b want 101", {valid_a, rd_a, busy_a}); end
    checks++; if (data_a !== 8'hA0) begin failures++; $display("FAIL bp_head: got %h want a0", data_a); end
    @(negedge rclk); m_ready = 1;
    wait_words(5);
    checks++; if (got_n !== 5) begin failures++; $display("FAIL bp_count: got %0d want 5", got_n); end
    for (int i = 0; i < 5 && i < got_n; i++) begin
      checks++; if (got_d[i] !== 8'(8'hA0 + 8'(i))) begin failures++; $display("FAIL bp_data[%0d]: got %h want %h", i, got_d[i], 8'(8'hA0 + 8'(i))); end
    end
  endtask

  task automatic test_timeout();
    bit seen = 0;
    do_reset();
    t_fempty = 0;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge rclk); #2; seen = rd_a; end
    checks++; if (seen !== 1'b1) begin failures++; $display("FAIL to_rd: got %b want 1", seen); end
    t_fempty = 1;
    repeat (4) @(negedge rclk); #2;
    checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL to_early: got %b want 0", err_a); end
    @(negedge rclk); #2;
    checks++; if ({err_a, valid_a, busy_a} !== 3'b100) begin failures++; $display("FAIL to_err: got %b want 100", {err_a, valid_a, busy_a}); end
    @(negedge rclk); t_q = 8'hEE; t_rack = 1;
    @(negedge rclk); t_rack = 0; #2;
    checks++; if ({err_a, valid_a, busy_a} !== 3'b100) begin failures++; $display("FAIL to_stray: got %b want 100", {err_a, valid_a, busy_a}); end
  endtask

  task automatic test_flush();
    int n = 0;
    do_reset();
    fmem[0] = 8'h30; fmem[1] = 8'hAA; fmem[2] = 8'h55; flen = 3; model_on = 1;
    for (int i = 0; i < 40 && n < 2; i++) begin @(negedge rclk); #2; if (rd_a) n++; end
    checks++; if ({n[1:0], valid_a} !== 3'b101) begin failures++; $display("FAIL fl_setup: got reads=%0d valid=%b want reads=2 valid=1", n, valid_a); end
    flush = 1;
    @(negedge rclk); flush = 0; #2;
    checks++; if ({valid_a, busy_a} !== 2'b01) begin failures++; $display("FAIL fl_clear: got %b want 01", {valid_a, busy_a}); end
    for (int i = 0; i < 20 && !valid_a; i++) begin @(negedge rclk); #2; end
    checks++; if (data_a !== 8'h55) begin failures++; $display("FAIL fl_next: got %h want 55", data_a); end
    checks++; if ({last_b, dut_b.idx_q} !== 3'b001) begin failures++; $display("FAIL fl_index: got last=%b idx=%0d want last=0 idx=1", last_b, dut_b.idx_q); end
    checks++; if (wc_a !== 16'd0) begin failures++; $display("FAIL fl_wc0: got %0d want 0", wc_a); end
    @(negedge rclk); m_ready = 1;
    @(negedge rclk); m_ready = 0; #2;
    checks++; if ({wc_a, valid_a} !== {16'd1, 1'b0}) begin failures++; $display("FAIL fl_deliver: got wc=%0d valid=%b want wc=1 valid=0", wc_a, valid_a); end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    do_reset();
    t_fempty = 0;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge rclk); #2; seen = rd_a; end
    t_fempty = 1;
    @(negedge rclk); t_q = 8'h61; t_rack = 1;
    @(negedge rclk); t_rack = 0; t_fempty = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge rclk); #2; seen = rd_a; end
    t_fempty = 1;
    @(negedge rclk); #2;
    checks++; if ({seen, valid_a, busy_a, data_a} !== {3'b111, 8'h61}) begin failures++; $display("FAIL rm_pre: got rd=%b valid=%b busy=%b data=%h want 1 1 1 61", seen, valid_a, busy_a, data_a); end
    rrst = 1; #2;
    checks++; if ({rd_a, valid_a, last_a, busy_a, err_a, data_a, wc_a} !== 29'd0) begin failures++; $display("FAIL rm_reset: got rd=%b v=%b l=%b b=%b e=%b d=%h wc=%0d want all 0", rd_a, valid_a, last_a, busy_a, err_a, data_a, wc_a); end
    @(negedge rclk); rrst = 0;
    @(negedge rclk); t_q = 8'h62; t_rack = 1;
    @(negedge rclk); t_rack = 0; #2;
    checks++; if ({valid_a, busy_a, wc_a} !== 18'd0) begin failures++; $display("FAIL rm_late_ack: got valid=%b busy=%b wc=%0d want 0 0 0", valid_a, busy_a, wc_a); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pkt();
    test_backpressure();
    test_timeout();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
